// File: rtl/cordic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// cordic_pkg : FSM states, mode codes and angle constants for the CORDIC
// Rev 1.0
// =====================================================================
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // Angle code = rad * 2^13
  localparam int PI_CODE = 25735;
  localparam int HALF_PI = PI_CODE / 2;
  localparam int TWO_PI  = 2 * PI_CODE;

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// cordic_atan_rom : atan(2^-i) * 2^13 (rounded), zero beyond ITER-1
// Rev 1.0
// =====================================================================
module cordic_atan_rom #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] atan
);

  logic [WIDTH-1:0] atan_raw;

  always_comb begin
    case (int'(idx))
      0:       atan_raw = WIDTH'(6434);
      1:       atan_raw = WIDTH'(3798);
      2:       atan_raw = WIDTH'(2007);
      3:       atan_raw = WIDTH'(1019);
      4:       atan_raw = WIDTH'(511);
      5:       atan_raw = WIDTH'(256);
      6:       atan_raw = WIDTH'(128);
      7:       atan_raw = WIDTH'(64);
      8:       atan_raw = WIDTH'(32);
      9:       atan_raw = WIDTH'(16);
      10:      atan_raw = WIDTH'(8);
      11:      atan_raw = WIDTH'(4);
      12:      atan_raw = WIDTH'(2);
      13:      atan_raw = WIDTH'(1);
      // i >= 14 rounds to zero at this angle scale
      default: atan_raw = '0;
    endcase
    atan = (int'(idx) < ITER) ? atan_raw : '0;
  end

endmodule
`default_nettype wire

// File: rtl/cordic_iter_multimode.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// cordic_iter_multimode : iterative rotation/vectoring CORDIC, one micro-rotation per cycle
// Rev 1.0
// =====================================================================
module cordic_iter_multimode
  import cordic_pkg::*;
#(
  parameter int WIDTH_WIRE  = 18,
  parameter int WIDTH       = 16,
  parameter int ITER        = 16,
  parameter int COUNT_WIDTH = 4,
  parameter int PI_CODE     = cordic_pkg::PI_CODE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic signed [WIDTH_WIRE-1:0] x_in,
  input  logic signed [WIDTH_WIRE-1:0] y_in,
  input  logic        [WIDTH-1:0]      z_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [WIDTH_WIRE+1:0] x_out,
  output logic signed [WIDTH_WIRE+1:0] y_out,
  output logic        [WIDTH-1:0]      z_out
);

  localparam int XW = WIDTH_WIRE + 2;
  localparam int ZW = WIDTH + 2;
  localparam logic signed [ZW-1:0] Z_PI       = ZW'(PI_CODE);
  localparam logic signed [ZW-1:0] Z_HALF_PI  = ZW'(PI_CODE / 2);
  localparam logic signed [ZW-1:0] Z_3HALF_PI = ZW'(3 * (PI_CODE / 2));
  localparam logic signed [ZW-1:0] Z_TWO_PI   = ZW'(2 * PI_CODE);
  localparam logic [COUNT_WIDTH-1:0] LAST     = COUNT_WIDTH'(ITER - 1);

  state_e state_q, state_d;

  logic                   live_q, live_d;
  logic                   mode_q, mode_d;
  logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]   z_q, z_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic signed [XW-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
  logic [WIDTH-1:0]       z_out_q, z_out_d;

  logic                   accept;
  logic [WIDTH-1:0]       atan_val;
  logic signed [ZW-1:0]   atan_z;
  logic signed [XW-1:0]   x_sh, y_sh, x_rot, y_rot;
  logic signed [ZW-1:0]   z_rot;
  logic                   d_pos;

  cordic_atan_rom #(
    .WIDTH (WIDTH),
    .ITER  (ITER),
    .IDX_W (COUNT_WIDTH)
  ) u_atan_rom (
    .idx  (cnt_q),
    .atan (atan_val)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PRE;
      ST_PRE:  state_d = ST_ITER;
      ST_ITER: if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // live_q keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = live_q && (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_z = {2'b00, atan_val};
    d_pos  = (mode_q == MODE_VEC) ? y_q[XW-1] : ~z_q[ZW-1];
    if (d_pos) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_z;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_z;
    end
  end

  always_comb begin
    live_d  = 1'b1;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d = mode;
          x_d    = {{2{x_in[WIDTH_WIRE-1]}}, x_in};
          y_d    = {{2{y_in[WIDTH_WIRE-1]}}, y_in};
          z_d    = {2'b00, z_in};
          cnt_d  = '0;
        end
      end
      // Fold the operand into the right half-plane so the micro-rotations converge
      ST_PRE: begin
        if (mode_q == MODE_VEC) begin
          if (x_q[XW-1]) begin
            x_d = -x_q;
            y_d = -y_q;
            z_d = Z_PI;
          end else begin
            z_d = '0;
          end
        end else if ((z_q >= Z_HALF_PI) && (z_q < Z_3HALF_PI)) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = z_q - Z_PI;
        end else if (z_q >= Z_3HALF_PI) begin
          z_d = z_q - Z_TWO_PI;
        end
      end
      ST_ITER: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          x_out_d = x_rot;
          y_out_d = y_rot;
          if (z_rot[ZW-1])            z_out_d = WIDTH'(z_rot + Z_TWO_PI);
          else if (z_rot >= Z_TWO_PI) z_out_d = WIDTH'(z_rot - Z_TWO_PI);
          else                        z_out_d = WIDTH'(z_rot);
        end else begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q  <= 1'b0;
      mode_q  <= MODE_ROT;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      live_q  <= live_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
    end
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_multimode.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// tb_cordic_iter_multimode : directed scoreboard bench for the iterative CORDIC
// Rev 1.0
// =====================================================================
module tb_cordic_iter_multimode;
  import cordic_pkg::*;

  localparam int  WW   = 18;
  localparam int  W    = 16;
  localparam int  IT   = 16;
  localparam int  CW   = 4;
  localparam int  XW   = WW + 2;
  localparam int  NOPS = 11;
  localparam real PI_R = 3.141592653589793;
  // Truncating shifts and the y==0 direction rule drift a few LSB from ideal math
  localparam int  TOL  = 12;

  typedef struct {
    longint ex, ey, ez;
    real    ix, iy, iz;
    bit     ideal;
    string  tag;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n, in_valid, mode, out_ready;
  logic                  in_ready, out_valid;
  logic signed [WW-1:0]  x_in, y_in;
  logic        [W-1:0]   z_in;
  logic signed [XW-1:0]  x_out, y_out;
  logic        [W-1:0]   z_out;

  exp_t   sb[$];
  exp_t   mon_e;
  int     errors = 0;
  int     checks = 0;
  int     atan_tab[IT];
  real    k_gain;

  always #5 clk = ~clk;

  cordic_iter_multimode #(
    .WIDTH_WIRE (WW),
    .WIDTH      (W),
    .ITER       (IT),
    .COUNT_WIDTH(CW),
    .PI_CODE    (PI_CODE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input real exp, input bit circ);
    real diff;
    bit  ok;
    diff = real'(obs) - exp;
    if (circ) begin
      while (diff >  TWO_PI / 2.0) diff = diff - TWO_PI;
      while (diff < -TWO_PI / 2.0) diff = diff + TWO_PI;
    end
    ok = (diff <= TOL) && (diff >= -TOL);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0.1f +/- %0d", tag, obs, exp, TOL);
    end
  endtask

  // Bit-level reference of the fold / micro-rotation / wrap algorithm
  task automatic model(input bit vec, input longint x0, input longint y0, input longint z0,
                       output longint xo, output longint yo, output longint zo);
    longint x, y, z, xs, ys;
    x = x0; y = y0; z = z0;
    if (vec) begin
      if (x < 0) begin x = -x; y = -y; z = PI_CODE; end
      else z = 0;
    end else if (z >= HALF_PI && z < 3 * HALF_PI) begin
      x = -x; y = -y; z = z - PI_CODE;
    end else if (z >= 3 * HALF_PI) begin
      z = z - TWO_PI;
    end
    for (int i = 0; i < IT; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (vec ? (y < 0) : (z >= 0)) begin
        x = x - ys; y = y + xs; z = z - atan_tab[i];
      end else begin
        x = x + ys; y = y - xs; z = z + atan_tab[i];
      end
    end
    if (z < 0) z = z + TWO_PI;
    else if (z >= TWO_PI) z = z - TWO_PI;
    xo = x; yo = y; zo = z;
  endtask

  task automatic push_op(input bit vec, input int xv, input int yv, input int zv,
                         input bit ideal, input string tag);
    exp_t e;
    real  th, ph;
    model(vec, xv, yv, zv, e.ex, e.ey, e.ez);
    if (vec) begin
      e.ix = k_gain * $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
      e.iy = 0.0;
      ph   = $atan2(real'(yv), real'(xv));
      if (ph < 0.0) ph = ph + 2.0 * PI_R;
      e.iz = ph / PI_R * PI_CODE;
    end else begin
      th   = real'(zv) / PI_CODE * PI_R;
      e.ix = k_gain * (real'(xv) * $cos(th) - real'(yv) * $sin(th));
      e.iy = k_gain * (real'(xv) * $sin(th) + real'(yv) * $cos(th));
      e.iz = 0.0;
    end
    e.ideal = ideal;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input bit vec, input int xv, input int yv, input int zv,
                      input bit ideal, input string tag);
    int g;
    g = 0;
    in_valid = 1'b1;
    mode     = vec;
    x_in     = WW'(xv);
    y_in     = WW'(yv);
    z_in     = W'(zv);
    while (in_ready !== 1'b1 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    assert (g < 100) else begin
      errors++;
      $error("FAIL %s accept: waited %0d cycles, limit 100", tag, g);
    end
    push_op(vec, xv, yv, zv, ideal, tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    assert (g < 200) else begin
      errors++;
      $error("FAIL %s completion: waited %0d cycles, limit 200", tag, g);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed x=%0d z=%0d, expected no result", x_out, z_out);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_x"}, longint'(x_out), mon_e.ex);
        check({mon_e.tag, "_y"}, longint'(y_out), mon_e.ey);
        check({mon_e.tag, "_z"}, longint'(z_out), mon_e.ez);
        if (mon_e.ideal) begin
          check_near({mon_e.tag, "_x_ideal"}, longint'(x_out), mon_e.ix, 1'b0);
          check_near({mon_e.tag, "_y_ideal"}, longint'(y_out), mon_e.iy, 1'b0);
          check_near({mon_e.tag, "_z_ideal"}, longint'(z_out), mon_e.iz, 1'b1);
        end
      end
    end
  end

  // mode, x, y, z_in, ideal-check flag
  int op_m[NOPS] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int op_x[NOPS] = '{0, -1000, 1000, -131072, 131071, 0, 1000, 1000, 1000, 1000, -700};
  int op_y[NOPS] = '{1000, 0, -1000, -131072, 131071, 0, 0, 0, 0, 0, 500};
  int op_z[NOPS] = '{0, 0, 0, 0, 0, 0, 12867, 25735, 0, 45036, 40000};
  int op_i[NOPS] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    real t;
    int  lat;
    longint hx, hy, hz;

    t = 1.0;
    k_gain = 1.0;
    for (int i = 0; i < IT; i++) begin
      atan_tab[i] = $rtoi($atan(t) * 8192.0 + 0.5);
      k_gain = k_gain * $sqrt(1.0 + t * t);
      t = t / 2.0;
    end

    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  longint'(in_ready),  0);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_x_out",     longint'(x_out),     0);
    check("reset_y_out",     longint'(y_out),     0);
    check("reset_z_out",     longint'(z_out),     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_in_ready", longint'(in_ready), 1);

    // Latency: in_valid presented for the cycle after edge 0, out_valid after edge 18
    in_valid = 1'b1; mode = 1'b1; x_in = 18'sd1000; y_in = '0; z_in = '0;
    push_op(1'b1, 1000, 0, 0, 1'b1, "vec_1000_0");
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
    end while (out_valid !== 1'b1 && lat < 40);
    check("latency", lat, 18);
    wait_idle("vec_1000_0");

    for (int i = 0; i < NOPS; i++) begin
      send(op_m[i][0], op_x[i], op_y[i], op_z[i], op_i[i][0], $sformatf("op%0d", i));
      wait_idle($sformatf("op%0d", i));
    end

    // Back-pressure: result held, new requests ignored
    out_ready = 1'b0;
    send(1'b1, 700, -300, 0, 1'b1, "bp_op");
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    hx = longint'(x_out); hy = longint'(y_out); hz = longint'(z_out);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; mode = c[0]; x_in = 18'sd5; y_in = -18'sd9; z_in = 16'd100;
      @(posedge clk); #1;
      check($sformatf("bp_out_valid_%0d", c), longint'(out_valid), 1);
      check($sformatf("bp_in_ready_%0d", c),  longint'(in_ready),  0);
      check($sformatf("bp_x_hold_%0d", c),    longint'(x_out),     hx);
      check($sformatf("bp_y_hold_%0d", c),    longint'(y_out),     hy);
      check($sformatf("bp_z_hold_%0d", c),    longint'(z_out),     hz);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready",  longint'(in_ready),  1);
    check("bp_release_out_valid", longint'(out_valid), 0);
    send(1'b0, -400, 900, 20000, 1'b1, "after_bp");
    wait_idle("after_bp");

    // Abort mid-iteration: counter is 7 in the cycle after the 9th edge past accept
    send(1'b1, 1000, 1000, 0, 1'b1, "aborted");
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_in_ready",  longint'(in_ready),  0);
    check("abort_x_out",     longint'(x_out),     0);
    check("abort_y_out",     longint'(y_out),     0);
    check("abort_z_out",     longint'(z_out),     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(1'b0, -500, 900, 6000, 1'b1, "after_abort");
    wait_idle("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
